// File: rtl/pulse_width_meter_if.sv
// Pulse-width meter signal bundle: measured input, consumer acknowledge and
// the held result with its status flags.
interface pulse_width_meter_if #(
  parameter int CNT_W = 16
);
  logic             in_i;
  logic             ack_i;
  logic [CNT_W-1:0] width_o;
  logic             valid_o;
  logic             overflow_o;
  logic             missed_o;
  logic             busy_o;

  modport master (
    output in_i,
    output ack_i,
    input  width_o,
    input  valid_o,
    input  overflow_o,
    input  missed_o,
    input  busy_o
  );

  modport slave (
    input  in_i,
    input  ack_i,
    output width_o,
    output valid_o,
    output overflow_o,
    output missed_o,
    output busy_o
  );
endinterface

// File: rtl/pulse_width_meter.sv
// Measures the high time of an asynchronous pulse in PRESCALE-cycle ticks and
// holds the result under a valid/ack handshake.
module pulse_width_meter #(
  parameter int PRESCALE  = 1000,
  parameter int CNT_W     = 16,
  parameter int MIN_TICKS = 1
) (
  input  logic              clk,
  input  logic              reset,
  pulse_width_meter_if.slave bus
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0]  PS_INIT  = PS_W'((PRESCALE == 1) ? 0 : 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((PRESCALE == 1) ? 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W:0]   MIN_T    = (CNT_W+1)'(MIN_TICKS);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    HOLD
  } state_e;

  logic            s1_q;
  logic            s2_q;
  logic            p_q;
  logic [1:0]      warm_q;
  logic            rise;
  logic            fall;

  state_e           state_q, state_d;
  logic [PS_W-1:0]  psc_q, psc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             ovf_q, ovf_d;
  logic             missed_q, missed_d;

  // Synchronizer and edge detector. The reset zeros in s1/s2 are not real
  // samples, so p stays at 1 until s carries a sampled value; an input held
  // high through reset release therefore never looks like a rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      p_q    <= 1'b1;
      warm_q <= 2'b00;
    end else begin
      s1_q   <= bus.in_i;
      s2_q   <= s1_q;
      warm_q <= {warm_q[0], 1'b1};
      p_q    <= warm_q[1] ? s2_q : 1'b1;
    end
  end

  assign rise = warm_q[1] &  s2_q & ~p_q;
  assign fall = warm_q[1] & ~s2_q &  p_q;

  // Measurement FSM state and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      psc_q    <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      width_q  <= '0;
      ovf_q    <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      psc_q    <= psc_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      width_q  <= width_d;
      ovf_q    <= ovf_d;
      missed_q <= missed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    psc_d    = psc_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    width_d  = width_q;
    ovf_d    = ovf_q;
    missed_d = missed_q;

    case (state_q)
      IDLE: begin
        // The rise cycle is already the first high cycle of the pulse.
        if (rise) begin
          state_d = MEASURE;
          psc_d   = PS_INIT;
          cnt_d   = CNT_INIT;
          sat_d   = 1'b0;
        end
      end

      MEASURE: begin
        if (fall) begin
          if ({1'b0, cnt_q} < MIN_T) begin
            state_d = IDLE;
          end else begin
            width_d = cnt_q;
            ovf_d   = sat_q;
            state_d = HOLD;
          end
        end else if (s2_q) begin
          if (psc_q == PS_LAST) begin
            psc_d = '0;
            if (cnt_q == CNT_MAX) begin
              sat_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            psc_d = psc_q + 1'b1;
          end
        end
      end

      HOLD: begin
        // ack wins over a simultaneous rise: that pulse is dropped, not flagged.
        if (bus.ack_i) begin
          missed_d = 1'b0;
          state_d  = IDLE;
        end else if (rise) begin
          missed_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.width_o    = width_q;
  assign bus.overflow_o = ovf_q;
  assign bus.missed_o   = missed_q;
  assign bus.valid_o    = (state_q == HOLD);
  assign bus.busy_o     = (state_q == MEASURE);

endmodule

// File: tb/tb_pulse_width_meter.sv
// Bench for pulse_width_meter: two instances (PRESCALE=4 and PRESCALE=1)
// compared every cycle against a run-length reference model.
module tb_pulse_width_meter;

  localparam int CNT_W     = 4;
  localparam int MIN_TICKS = 1;
  localparam int MAXV      = (1 << CNT_W) - 1;
  localparam int PS [2]    = '{4, 1};
  localparam int MD_IDLE   = 0;
  localparam int MD_MEAS   = 1;
  localparam int MD_HOLD   = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_v [2];
  logic ack_v [2];

  int total = 0;
  int bad = 0;

  // reference model state, one set per instance
  int m_s1 [2];
  int m_s2 [2];
  int m_prev [2];
  int m_k [2];
  int m_mode [2];
  int m_h [2];
  int m_width [2];
  int m_ovf [2];
  int m_miss [2];

  always #5 clk = ~clk;

  pulse_width_meter_if #(.CNT_W(CNT_W)) bus4 ();
  pulse_width_meter_if #(.CNT_W(CNT_W)) bus1 ();

  assign bus4.in_i  = in_v[0];
  assign bus4.ack_i = ack_v[0];
  assign bus1.in_i  = in_v[1];
  assign bus1.ack_i = ack_v[1];

  pulse_width_meter #(.PRESCALE(4), .CNT_W(CNT_W), .MIN_TICKS(MIN_TICKS)) dut4 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus4.slave)
  );

  pulse_width_meter #(.PRESCALE(1), .CNT_W(CNT_W), .MIN_TICKS(MIN_TICKS)) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1.slave)
  );

  function automatic void chk(string nm, int d, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0d want=%0d at %0t", nm, d, act, exp, $time);
    end
  endfunction

  task automatic model_reset(int d);
    m_s1[d] = 0; m_s2[d] = 0; m_prev[d] = 1; m_k[d] = 0;
    m_mode[d] = MD_IDLE; m_h[d] = 0;
    m_width[d] = 0; m_ovf[d] = 0; m_miss[d] = 0;
  endtask

  // One clock edge of the reference: a pulse is the run of high cycles on the
  // synchronized input; its width is floor(run/PRESCALE), clamped.
  task automatic step_model();
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        model_reset(d);
      end else begin
        int s, known, rise, t;
        known = (m_k[d] >= 2);
        s     = m_s2[d];
        rise  = known && (s == 1) && (m_prev[d] == 0);
        case (m_mode[d])
          MD_IDLE: if (rise) begin
            m_mode[d] = MD_MEAS;
            m_h[d] = 1;
          end
          MD_MEAS: if (s == 1) begin
            m_h[d]++;
          end else begin
            t = m_h[d] / PS[d];
            if ((t > MAXV ? MAXV : t) < MIN_TICKS) begin
              m_mode[d] = MD_IDLE;
            end else begin
              m_width[d] = (t > MAXV) ? MAXV : t;
              m_ovf[d]   = (t > MAXV) ? 1 : 0;
              m_mode[d]  = MD_HOLD;
            end
          end
          default: if (ack_v[d]) begin
            m_miss[d] = 0;
            m_mode[d] = MD_IDLE;
          end else if (rise) begin
            m_miss[d] = 1;
          end
        endcase
        if (known) m_prev[d] = s;
        m_s2[d] = m_s1[d];
        m_s1[d] = int'(in_v[d]);
        if (m_k[d] < 2) m_k[d]++;
      end
    end
  endtask

  task automatic compare_all();
    int aw [2], av [2], ao [2], am [2], ab [2];
    aw[0] = int'(bus4.width_o); av[0] = int'(bus4.valid_o); ao[0] = int'(bus4.overflow_o);
    am[0] = int'(bus4.missed_o); ab[0] = int'(bus4.busy_o);
    aw[1] = int'(bus1.width_o); av[1] = int'(bus1.valid_o); ao[1] = int'(bus1.overflow_o);
    am[1] = int'(bus1.missed_o); ab[1] = int'(bus1.busy_o);
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        chk("rst_width", d, aw[d], 0);
        chk("rst_valid", d, av[d], 0);
        chk("rst_overflow", d, ao[d], 0);
        chk("rst_missed", d, am[d], 0);
        chk("rst_busy", d, ab[d], 0);
      end else begin
        chk("width", d, aw[d], m_width[d]);
        chk("valid", d, av[d], (m_mode[d] == MD_HOLD) ? 1 : 0);
        chk("overflow", d, ao[d], m_ovf[d]);
        chk("missed", d, am[d], m_miss[d]);
        chk("busy", d, ab[d], (m_mode[d] == MD_MEAS) ? 1 : 0);
      end
    end
  endtask

  // Outputs are compared 1 time unit after the edge; inputs change 2 after it.
  task automatic cyc();
    @(posedge clk);
    step_model();
    #1;
    compare_all();
    #1;
  endtask

  task automatic pulse(int d, int hi, int lo);
    in_v[d] = 1'b1;
    repeat (hi) cyc();
    in_v[d] = 1'b0;
    repeat (lo) cyc();
  endtask

  task automatic do_ack(int d);
    ack_v[d] = 1'b1;
    cyc();
    ack_v[d] = 1'b0;
  endtask

  initial begin
    int rem [2];
    in_v[0] = 1'b0; in_v[1] = 1'b0;
    ack_v[0] = 1'b0; ack_v[1] = 1'b0;
    model_reset(0);
    model_reset(1);

    repeat (3) cyc();
    chk("lit_reset_width", 0, int'(bus4.width_o), 0);
    chk("lit_reset_valid", 0, int'(bus4.valid_o), 0);
    reset = 1'b0;
    repeat (3) cyc();

    // basic measurement
    pulse(0, 40, 4);
    chk("lit_basic_width", 0, int'(bus4.width_o), 10);
    chk("lit_basic_valid", 0, int'(bus4.valid_o), 1);
    chk("lit_basic_ovf", 0, int'(bus4.overflow_o), 0);
    chk("lit_basic_missed", 0, int'(bus4.missed_o), 0);
    do_ack(0);
    chk("lit_ack_valid", 0, int'(bus4.valid_o), 0);
    chk("lit_ack_busy", 0, int'(bus4.busy_o), 0);

    // glitch rejection
    pulse(0, 3, 4);
    chk("lit_glitch_valid", 0, int'(bus4.valid_o), 0);
    chk("lit_glitch_width", 0, int'(bus4.width_o), 10);
    pulse(0, 7, 4);
    chk("lit_7clk_width", 0, int'(bus4.width_o), 1);
    do_ack(0);

    // saturation
    pulse(0, 100, 4);
    chk("lit_sat_width", 0, int'(bus4.width_o), 15);
    chk("lit_sat_ovf", 0, int'(bus4.overflow_o), 1);
    do_ack(0);
    pulse(0, 20, 4);
    chk("lit_20clk_width", 0, int'(bus4.width_o), 5);
    chk("lit_20clk_ovf", 0, int'(bus4.overflow_o), 0);
    do_ack(0);

    // pending result
    pulse(0, 40, 4);
    pulse(0, 80, 4);
    chk("lit_pend_width", 0, int'(bus4.width_o), 10);
    chk("lit_pend_missed", 0, int'(bus4.missed_o), 1);
    do_ack(0);
    chk("lit_pend_ack_valid", 0, int'(bus4.valid_o), 0);
    chk("lit_pend_ack_missed", 0, int'(bus4.missed_o), 0);
    pulse(0, 12, 4);
    chk("lit_12clk_width", 0, int'(bus4.width_o), 3);

    // reset mid-pulse, released while the input is still high
    pulse(0, 20, 0);
    in_v[0] = 1'b1;
    reset = 1'b1;
    #1;
    chk("lit_midrst_width", 0, int'(bus4.width_o), 0);
    chk("lit_midrst_valid", 0, int'(bus4.valid_o), 0);
    chk("lit_midrst_busy", 0, int'(bus4.busy_o), 0);
    repeat (3) cyc();
    reset = 1'b0;
    repeat (10) cyc();
    in_v[0] = 1'b0;
    repeat (6) cyc();
    chk("lit_post_rst_valid", 0, int'(bus4.valid_o), 0);
    chk("lit_post_rst_busy", 0, int'(bus4.busy_o), 0);
    pulse(0, 16, 4);
    chk("lit_16clk_width", 0, int'(bus4.width_o), 4);
    do_ack(0);

    // PRESCALE=1
    pulse(1, 9, 4);
    chk("lit_p1_width9", 1, int'(bus1.width_o), 9);
    do_ack(1);
    pulse(1, 1, 4);
    chk("lit_p1_width1", 1, int'(bus1.width_o), 1);
    chk("lit_p1_valid", 1, int'(bus1.valid_o), 1);
    do_ack(1);

    // randomized traffic on both instances
    rem[0] = 0; rem[1] = 0;
    for (int n = 0; n < 4000; n++) begin
      for (int d = 0; d < 2; d++) begin
        if (rem[d] == 0) begin
          in_v[d] = ~in_v[d];
          rem[d] = (d == 0) ? int'($urandom_range(1, 80)) : int'($urandom_range(1, 20));
        end
        rem[d]--;
        ack_v[d] = ($urandom_range(0, 5) == 0);
      end
      reset = ((n % 900) >= 896);
      cyc();
    end
    reset = 1'b0;
    ack_v[0] = 1'b0; ack_v[1] = 1'b0;
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_width_meter.md
# pulse_width_meter

Measures the high time of an asynchronous single-bit pulse and reports it in prescaled ticks. It is the receive-side counterpart of the team's pulse generators, and runs on the same 1 MHz system clock. A 2-flop synchronizer feeds an edge detector and a measurement FSM. The measured width is held in a register under a valid/ack handshake until software or downstream logic consumes it.

## Interface
- PRESCALE, 1000: clk cycles per tick; legal range 1..2^20. The default gives 1 ms ticks at 1 MHz.
- CNT_W, 16: width of the tick counter and of the `width` output.
- MIN_TICKS, 1: pulses measuring fewer ticks than this are rejected as glitches. A value of 0 accepts every pulse.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- in  in  1  asynchronous pulse input to be measured.
- ack  in  1  consumer acknowledge; sampled only while `valid`=1.
- width  out  CNT_W  last accepted pulse width in ticks; stable while `valid`=1.
- valid  out  1  a measurement is held and not yet acknowledged.
- overflow  out  1  the held measurement saturated; qualified by `valid`.
- missed  out  1  sticky flag: a rising edge arrived while a result was pending.
- busy  out  1  the FSM is in MEASURE.

## Operation
- **Synchronizer and edge detect**
  - `in` passes through s1 then s2, both reset to 0, giving the synchronized signal `s`.
  - A third flop p holds the previous `s` and resets to **1**. Consequently an `in` held high through reset release produces no measurement; the block first needs to see `in` low.
  - rise = s & ~p; fall = ~s & p.
- **FSM states:** IDLE, MEASURE, HOLD. Reset state is IDLE.
- **IDLE**
  - On rise: go to MEASURE. The rise cycle counts as the first high cycle, so load prescaler=1 and cnt=0. If PRESCALE=1, load prescaler=0 and cnt=1 instead.
- **MEASURE** (busy=1)
  - Each cycle with s=1, the prescaler increments.
  - When the prescaler reaches PRESCALE-1 it wraps to 0 and cnt increments. cnt saturates at 2^CNT_W-1; an increment attempted at saturation sets an internal sat bit.
  - Result: cnt = min(floor(H/PRESCALE), 2^CNT_W-1), where H is the number of consecutive cycles with s=1.
- **MEASURE on fall**
  - If cnt < MIN_TICKS: discard and return to IDLE. width, valid, overflow and missed are unchanged.
  - Otherwise: width<=cnt, overflow<=sat, valid<=1, and go to HOLD.
- **HOLD** (valid=1)
  - width and overflow are frozen.
  - A rise in HOLD sets missed=1. The pulse is not measured.
  - ack=1 sampled in HOLD: valid<=0 and missed<=0, then go to IDLE.
  - If a rise and an ack occur in the same cycle, the ack wins: missed is cleared and that pulse is lost. The FSM does not enter MEASURE mid-pulse.
- **Outside HOLD**
  - ack is ignored.
  - width keeps its last value after ack. It resets to 0 only on reset.
- **Reset**
  - Asynchronous, effective at any time, including mid-measurement.
  - All outputs go to 0 (width=0, valid=0, overflow=0, missed=0, busy=0). The FSM returns to IDLE, and the prescaler, cnt and sat clear.
  - A partial measurement is discarded.

## Timing
- **Input to s:** 2 clk latency.
- **Rising edge of `in` to busy=1:** busy is high after the 3rd clk edge following the `in` rise (setup met).
- **Falling edge of `in` to valid=1:** valid is high after the 3rd clk edge following the `in` fall. width and overflow update on the same edge as valid.
- **ack to valid=0:** valid=0 on the clk edge that samples ack=1, i.e. 1-cycle turnaround. The earliest next measurement begins on a rise detected in the following cycle.
- **Minimum low time between measurable pulses:** 2 clk cycles on `s`, given an immediate ack.
- **Resolution:** ±1 clk cycle from synchronizer phase uncertainty. The width value is truncated (floor), never rounded.

## Test plan
Bench parameters: PRESCALE=4, CNT_W=4, MIN_TICKS=1 unless noted.

- **Basic measurement:** `in` high 40 clk, then low -> valid=1 with width=10, overflow=0, missed=0. ack for 1 cycle -> valid=0 the next cycle and busy=0.
- **Glitch rejection:** `in` high 3 clk -> floor(3/4)=0 < MIN_TICKS, so valid stays 0 and width keeps its prior value. Then a 7-clk pulse -> width=1.
- **Saturation:** `in` high 100 clk -> width=15, overflow=1. Next, a 20-clk pulse with an ack between -> width=5, overflow=0.
- **Pending result:** 40-clk pulse, no ack, then an 80-clk pulse -> width stays 10 and missed=1. ack -> valid=0 and missed=0. A following 12-clk pulse gives width=3.
- **Reset mid-operation:** assert reset 20 clk into a pulse -> all outputs 0 immediately. Release reset while `in` is still high -> no valid. Then a complete 16-clk pulse -> width=4.
- **PRESCALE=1:** `in` high 9 clk -> width=9. A single-cycle pulse that reaches s -> width=1, valid=1.
